// File: rtl/uart_pkg.sv
// Shared UART constants and types; the receiver and the receive FIFO agree on UART_DATA_SIZE.
package uart_pkg;

   localparam int UART_DATA_SIZE       = 8;
   localparam int UART_FIFO_ADDR_WIDTH = 4;
   localparam int UART_FIFO_AF_LEVEL   = 12;

   // rx_done edge detector: HELD means rx_done was high on the previous clk edge.
   typedef enum logic {
      EDGE_IDLE = 1'b0,
      EDGE_HELD = 1'b1
   } edge_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: unregistered write port, registered read port.
module uart_fifo_mem #(
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_SIZE-1:0]  i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_SIZE-1:0]  o_rd_data
);

   logic [DATA_SIZE-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
   logic [DATA_SIZE-1:0] r_rd_data;

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // A read of the slot being written in the same cycle returns the old word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: one write per rx_done assertion, registered read.
// Sticky overrun reporting is built only when UART_RX_FIFO_OVERRUN_EN is defined.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_SIZE  = UART_DATA_SIZE,
   parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
   parameter int AF_LEVEL   = UART_FIFO_AF_LEVEL
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx_done,
   input  logic [DATA_SIZE-1:0]  rx_data,
   input  logic                  rd_en,
   output logic [DATA_SIZE-1:0]  rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overrun,
   input  logic                  overrun_clr,
   output edge_state_t           dbg_edge_state
);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);

   logic [ADDR_WIDTH:0] r_wr_ptr;
   logic [ADDR_WIDTH:0] r_rd_ptr;
   logic                r_rd_valid;
   edge_state_t         r_edge_state;
   edge_state_t         w_edge_next;
   logic                w_wr_req;
   logic                w_rd_fire;
   logic                w_wr_en;

   // Edge detector: state register, next state, output decode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_edge_state <= EDGE_IDLE;
      else          r_edge_state <= w_edge_next;
   end

   always_comb begin
      w_edge_next = EDGE_IDLE;
      if (rx_done) w_edge_next = EDGE_HELD;
   end

   always_comb begin
      w_wr_req = 1'b0;
      if (r_edge_state == EDGE_IDLE && rx_done) w_wr_req = 1'b1;
   end

   assign dbg_edge_state = r_edge_state;

   assign level       = r_wr_ptr - r_rd_ptr;
   assign empty       = (level == '0);
   assign full        = (level == DEPTH_L);
   assign almost_full = (level >= AF_L);

   // Read handshake: rd_en is a request taken only while !empty; rd_valid pulses
   // for exactly one cycle on the edge after acceptance, with rd_data alongside.
   assign w_rd_fire = rd_en & ~empty;
   // A pop in the same cycle frees the slot a full-FIFO write needs.
   assign w_wr_en   = w_wr_req & (~full | w_rd_fire);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_wr_en)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_rd_valid <= w_rd_fire;
      end
   end

   assign rd_valid = r_rd_valid;

   uart_fifo_mem #(
      .DATA_SIZE  (DATA_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wr_data (rx_data),
      .i_rd_en   (w_rd_fire),
      .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rd_data (rd_data)
   );

`ifdef UART_RX_FIFO_OVERRUN_EN
   logic r_overrun;
   logic w_drop;

   assign w_drop = w_wr_req & full & ~w_rd_fire;

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         r_overrun <= 1'b0;
      else if (w_drop)      r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
   end

   assign overrun = r_overrun;
`else
   logic w_unused_overrun_clr;

   assign w_unused_overrun_clr = overrun_clr;
   assign overrun              = 1'b0;
`endif

endmodule
